// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM controller.
// Holds the FSM state encoding, ALU operation codes, data-processing cmd
// encodings, condition-field encodings, datapath select constants and the
// packed bundle of registered control outputs.
package arm_ctrl_pkg;

  // Controller states. The encoding is visible on state_o.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // ALU operation codes (zero-extended onto alu_control).
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_ORR    = 3'd3;
  localparam logic [2:0] ALU_EOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;

  // Data-processing cmd field, instr[24:21].
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Condition field, instr[31:28].
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // alu_src_b selects.
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // result_src selects.
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [3:0] REG_PC = 4'd15;

  // Registered control outputs driven by the FSM.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_op;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '0;

  // FETCH: write IR, PC := PC + 4 taken directly from the ALU.
  localparam ctl_t CTL_FETCH = '{
    pc_write:   1'b1,
    adr_src:    1'b0,
    mem_write:  1'b0,
    ir_write:   1'b1,
    reg_write:  1'b0,
    alu_src_a:  1'b1,
    alu_src_b:  SRCB_FOUR,
    result_src: RES_ALU,
    alu_op:     ALU_ADD
  };

endpackage

// File: rtl/arm_cond_check.sv
// Condition-field evaluator.
// Ports:
//   cond    - instr[31:28]
//   flags   - architectural {N,Z,C,V}
//   cond_ok - 1 when the instruction should execute; cond=1111 never executes
// Purely combinational.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;  // COND_NV
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM controller: Moore FSM sequencing FETCH, DECODE, execute,
// memory and writeback over a shared memory/ALU datapath, with an NZCV flag
// register and conditional execution.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   cond/op/funct/rd/sh - instruction fields from the instruction register
//   alu_flags          - ALU {N,Z,C,V} for the current cycle
//   pc_write, ir_write, reg_write, mem_write - enables (0 while in reset)
//   adr_src, alu_src_a, alu_src_b, result_src, alu_control - datapath selects
//   imm_src, reg_src, shift_rl - instruction-decoded selects
//   flags              - registered NZCV
//   state_o            - current FSM state
// Control outputs are registered: they are computed from the next state, so
// a writeback state's enables use the condition result evaluated before the
// preceding execute state updates the flags.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W   = 3,
  parameter bit         ENABLE_COND = 1'b1,
  parameter logic [3:0] FLAGS_RST   = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           cond,
  input  logic [1:0]           op,
  input  logic [5:0]           funct,
  input  logic [3:0]           rd,
  input  logic [1:0]           sh,
  input  logic [3:0]           alu_flags,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic [1:0]           reg_src,
  output logic                 shift_rl,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [3:0]           flags,
  output logic [3:0]           state_o
);

  state_t     state, nxt;
  ctl_t       ctl_d, ctl_q;
  logic [3:0] flags_q;
  logic       cond_ok, condex;

  logic [3:0] cmd;
  logic       s_bit;
  logic [2:0] dp_alu;
  logic       dp_defined, dp_writes, dp_arith;

  logic unused_sh;
  assign unused_sh = sh[1];

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  arm_cond_check u_cond (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ok (cond_ok)
  );

  assign condex = ENABLE_COND ? cond_ok : 1'b1;

  // Data-processing decode. Undefined cmds compute ADD but neither write a
  // register nor touch the flags.
  always_comb begin
    dp_alu     = ALU_ADD;
    dp_defined = 1'b1;
    dp_writes  = 1'b1;
    dp_arith   = 1'b0;
    case (cmd)
      CMD_AND: dp_alu = ALU_AND;
      CMD_EOR: dp_alu = ALU_EOR;
      CMD_SUB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
      CMD_ADD: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_MOV: dp_alu = ALU_PASS_B;
      CMD_CMP: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_writes = 1'b0; end
      default: begin dp_defined = 1'b0; dp_writes = 1'b0; end
    endcase
  end

  // Next-state logic. Unused encodings recover to FETCH.
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   nxt = S_MEMADR;
          2'b00:   nxt = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   nxt = S_BRANCH;
          default: nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXECR:  nxt = S_ALUWB;
      S_EXECI:  nxt = S_ALUWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // Control values for the state being entered.
  always_comb begin
    ctl_d = CTL_IDLE;
    case (nxt)
      S_FETCH:  ctl_d = CTL_FETCH;
      S_DECODE: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = SRCB_FOUR;
        ctl_d.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctl_d.alu_src_b = SRCB_IMM;
        ctl_d.alu_op    = ALU_ADD;
      end
      S_MEMRD:  ctl_d.adr_src = 1'b1;
      S_MEMWB: begin
        ctl_d.result_src = RES_MEM;
        ctl_d.reg_write  = condex;
      end
      S_MEMWR: begin
        ctl_d.adr_src   = 1'b1;
        ctl_d.mem_write = condex;
      end
      S_EXECR: begin
        ctl_d.alu_src_b = SRCB_REG;
        ctl_d.alu_op    = dp_alu;
      end
      S_EXECI: begin
        ctl_d.alu_src_b = SRCB_IMM;
        ctl_d.alu_op    = dp_alu;
      end
      S_ALUWB: begin
        ctl_d.result_src = RES_ALUOUT;
        ctl_d.reg_write  = condex & dp_writes & (rd != REG_PC);
        ctl_d.pc_write   = condex & dp_writes & (rd == REG_PC);
      end
      S_BRANCH: begin
        ctl_d.alu_src_b  = SRCB_IMM;
        ctl_d.alu_op     = ALU_ADD;
        ctl_d.result_src = RES_ALU;
        ctl_d.pc_write   = condex;
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      ctl_q   <= CTL_FETCH;
      flags_q <= FLAGS_RST;
    end else begin
      state <= nxt;
      ctl_q <= ctl_d;
      // Flags land at the end of execute; the writeback enables registered
      // on this same edge were computed from the old flags.
      if ((state == S_EXECR || state == S_EXECI) && condex &&
          (s_bit || cmd == CMD_CMP) && dp_defined) begin
        flags_q[3:2] <= alu_flags[3:2];
        if (dp_arith) flags_q[1:0] <= alu_flags[1:0];
      end
    end
  end

  // Enables are gated by rst_n so they fall the moment reset asserts, while
  // the registered FETCH values are ready on the first cycle after release.
  assign pc_write    = ctl_q.pc_write  & rst_n;
  assign ir_write    = ctl_q.ir_write  & rst_n;
  assign reg_write   = ctl_q.reg_write & rst_n;
  assign mem_write   = ctl_q.mem_write & rst_n;
  assign adr_src     = ctl_q.adr_src;
  assign alu_src_a   = ctl_q.alu_src_a;
  assign alu_src_b   = ctl_q.alu_src_b;
  assign result_src  = ctl_q.result_src;
  assign alu_control = ALUCTRL_W'(ctl_q.alu_op);

  assign imm_src  = op;
  assign reg_src  = {(op == 2'b01) && !funct[0], (op == 2'b10)};
  assign shift_rl = (op == 2'b00) && (cmd == CMD_MOV) && sh[0];

  assign flags   = flags_q;
  assign state_o = state;

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Multicycle successor to the single-cycle ARM controller. A Moore FSM sequences fetch, decode, execute, memory and writeback over a shared memory/ALU datapath. Adds an architectural NZCV flag register, conditional execution on the instruction cond field, branches, and writes to R15. Drives every datapath mux and enable; it is the only sequential control block in the core.

Parameters:
ALUCTRL_W, 3, width of alu_control; must be >= 3.
ENABLE_COND, 1, 1 = honour cond field; 0 = treat every instruction as AL.
FLAGS_RST, 4'b0000, reset value of the NZCV register.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cond  in  4  instr[31:28]
op  in  2  instr[27:26]
funct  in  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S or L
rd  in  4  instr[15:12]
sh  in  2  instr[6:5] shift type
alu_flags  in  4  {N,Z,C,V} from ALU, current cycle
pc_write  out  1  PC register enable
adr_src  out  1  0=PC, 1=ALU result register as memory address
mem_write  out  1  data memory write enable
ir_write  out  1  instruction register enable
reg_write  out  1  register file write enable
alu_src_a  out  1  0=register A, 1=PC
alu_src_b  out  2  0=register B, 1=ExtImm, 2=constant 4
result_src  out  2  0=ALUOut reg, 1=memory data, 2=ALU direct
imm_src  out  2  equals op
reg_src  out  2  [0]=branch (Rn:=R15), [1]=store (Rm:=Rd)
shift_rl  out  1  MOV with sh[0]=1 selects right shift
alu_control  out  ALUCTRL_W  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 PASS_B
flags  out  4  registered NZCV
state_o  out  4  current state, for debug and bench

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH, flags=FLAGS_RST. All enables (pc_write, ir_write, reg_write, mem_write) forced 0 while rst_n=0. Other outputs take their FETCH values.
- Reset mid-instruction aborts it with no partial write. First edge after release performs FETCH.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=2, ADD, result_src=2. Next state DECODE.
- DECODE: alu_src_a=1, alu_src_b=2, ADD (forms PC+8). Next state:
  - op=01 -> MEMADR
  - op=00, funct[5]=0 -> EXECR
  - op=00, funct[5]=1 -> EXECI
  - op=10 -> BRANCH
  - op=11 -> FETCH (no-op)
- MEMADR: alu_src_b=1, ADD. funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD: adr_src=1, then MEMWB.
- MEMWB: result_src=1, reg_write=condex, then FETCH.
- MEMWR: adr_src=1, mem_write=condex, then FETCH.
- EXECR/EXECI: alu_src_b=0 or 1, alu_control from cmd, then ALUWB.
- ALUWB: result_src=0, then FETCH.
  - reg_write=condex & writes & (rd!=15).
  - pc_write=condex & writes & (rd==15).
- BRANCH: alu_src_b=1, ADD, result_src=2, pc_write=condex, then FETCH.
- Latency: DP 4 cycles, LDR 5, STR 4, B 3, op=11 2.
- cmd decode:
  - 0000 AND, 0001 EOR, 0010 SUB, 0100 ADD, 1100 ORR, 1101 MOV(PASS_B), 1010 CMP(SUB).
  - writes=0 for CMP and for undefined cmds.
  - Undefined cmd: alu_control=ADD, no write, no flag update.
- condex (combinational from cond and flags): EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. cond=1111 is treated as never. ENABLE_COND=0 forces condex=1.
- Flag update at the end of EXECR/EXECI when condex & (S | CMP) & cmd defined:
  - N,Z always updated.
  - C,V updated only for ADD, SUB, CMP; logical ops and MOV keep the old C,V.
- Flags update after condex has been evaluated. An instruction never sees its own flag result.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state enum (4-bit)
  - ALU op codes
  - cmd encodings
  - cond encodings
  - alu_src_b and result_src select constants
- One sub-module, arm_cond_check: cond + flags -> condex, purely combinational.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> state_o=FETCH, flags=0000, enables 0 during reset; ir_write=1 and pc_write=1 on the first cycle after release.
- ADDS, result zero: op=00, funct=101001 (I, ADD, S) with alu_flags=0110 in EXECI -> sequence FETCH, DECODE, EXECI, ALUWB; reg_write=1 in ALUWB; flags=0110.
- CMP then conditional MOV:
  - CMP with alu_flags=0100 -> flags=0100, reg_write=0.
  - MOVEQ (cond=0000) -> reg_write=1.
  - MOVNE (cond=0001) -> reg_write=0 and flags unchanged.
- Loads, stores and branches:
  - LDR (op=01, funct[0]=1) -> 5 states; reg_write only in MEMWB with result_src=1.
  - STR -> mem_write=1 only in MEMWR, reg_src=10.
  - B (op=10) -> 3 states, pc_write=1 in BRANCH.
- ANDS with alu_flags=1010 when flags=0011 -> flags=1011 (C,V preserved).
- DP with rd=15 -> pc_write=1, reg_write=0 in ALUWB.
- Reset asserted during MEMWR -> mem_write drops to 0 immediately and state_o=FETCH.
